// File: rtl/amba3_apb_regfile.sv
// APB (AMBA 3) register bank: NUM_REGS registers, programmable wait states,
// PSLVERR on bad decode or RO writes, and a hardware-side update port for status registers.
module amba3_apb_regfile #(
  parameter int                  ADDR_SIZE   = 32,
  parameter int                  DATA_SIZE   = 32,
  parameter int                  NUM_REGS    = 16,
  parameter int                  BASE_ADDR   = 0,
  parameter int                  WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
  input  logic                          pclk,
  input  logic                          preset_n,
  input  logic [ADDR_SIZE-1:0]          paddr,
  input  logic                          psel,
  input  logic                          penable,
  input  logic                          pwrite,
  input  logic [DATA_SIZE-1:0]          pwdata,
  output logic                          pready,
  output logic [DATA_SIZE-1:0]          prdata,
  output logic                          pslverr,
  output logic [NUM_REGS*DATA_SIZE-1:0] reg_q,
  input  logic [NUM_REGS-1:0]           hw_we,
  input  logic [NUM_REGS*DATA_SIZE-1:0] hw_wdata,
  output logic [NUM_REGS-1:0]           wr_pulse,
  output logic                          state_dbg
);

  localparam int AL = $clog2(DATA_SIZE / 8);
  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_SIZE-1:0] BASE  = ADDR_SIZE'(BASE_ADDR);
  localparam logic [ADDR_SIZE-1:0] AMASK = ADDR_SIZE'((1 << AL) - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t               state, state_n;
  logic [3:0]           cnt, cnt_n;
  logic [DATA_SIZE-1:0] regs [NUM_REGS];
  logic [ADDR_SIZE-1:0] off, idx;
  logic [IW-1:0]        idx_s;
  logic                 in_range, misaligned, ro_hit, err;
  logic                 complete, commit;
  logic [NUM_REGS-1:0]  sel_oh;

  // Address decode; off wraps so addresses below BASE land far out of range.
  always_comb begin
    off        = paddr - BASE;
    idx        = off >> AL;
    idx_s      = idx[IW-1:0];
    misaligned = |(off & AMASK);
    in_range   = (idx < ADDR_SIZE'(NUM_REGS));
    ro_hit     = in_range && RO_MASK[idx_s];
    err        = misaligned || !in_range || (pwrite && ro_hit);
    for (int i = 0; i < NUM_REGS; i++) sel_oh[i] = (idx_s == IW'(i));
  end

  // Handshake: a setup (psel=1, penable=0) at an edge opens ACCESS; the transfer
  // completes at the first edge with psel=penable=1 while pready=1; psel=0 in
  // ACCESS aborts without side effects. pready/pslverr/prdata are valid only together.
  assign pready   = (state == ACCESS) && (cnt == 4'd0);
  assign pslverr  = pready && err;
  assign complete = pready && psel && penable;
  assign commit   = complete && pwrite && !err;
  assign state_dbg = (state == ACCESS);

  always_comb begin
    prdata = '0;
    if (pready && !pwrite && !err) prdata = regs[idx_s];
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (psel && !penable) begin
      state_n = ACCESS;
      cnt_n   = 4'(WAIT_STATES);
    end else if (state == ACCESS) begin
      if (!psel) begin
        state_n = IDLE;
      end else if (penable) begin
        if (cnt != 4'd0) cnt_n = cnt - 4'd1;
        else             state_n = IDLE;
      end
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      wr_pulse <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      wr_pulse <= commit ? sel_oh : '0;
    end
  end

  // RO registers take only hardware writes and RW only APB writes, so they never collide.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (RO_MASK[i] && hw_we[i])   regs[i] <= hw_wdata[i*DATA_SIZE +: DATA_SIZE];
        else if (commit && sel_oh[i]) regs[i] <= pwdata;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) reg_q[i*DATA_SIZE +: DATA_SIZE] = regs[i];
  end

endmodule

// File: tb/tb_amba3_apb_regfile.sv
// Bench for amba3_apb_regfile: two instances (0 and 3 wait states) sharing the APB bus
// apart from psel, checked against a register model and an expected-response queue.
module tb_amba3_apb_regfile;

  logic         pclk, preset_n;
  logic [31:0]  paddr, pwdata;
  logic         psel0, psel3, penable, pwrite;
  logic [15:0]  hw_we;
  logic [511:0] hw_wdata;

  logic         pready0, pslverr0, sd0, pready3, pslverr3, sd3;
  logic [31:0]  prdata0, prdata3;
  logic [511:0] reg_q0, reg_q3;
  logic [15:0]  wr_pulse0, wr_pulse3;

  amba3_apb_regfile #(.ADDR_SIZE(32), .DATA_SIZE(32), .NUM_REGS(16), .BASE_ADDR(32'h1000),
    .WAIT_STATES(0), .RO_MASK(16'h0008)) dut0 (
    .pclk(pclk), .preset_n(preset_n), .paddr(paddr), .psel(psel0), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pready(pready0), .prdata(prdata0), .pslverr(pslverr0),
    .reg_q(reg_q0), .hw_we(hw_we), .hw_wdata(hw_wdata), .wr_pulse(wr_pulse0), .state_dbg(sd0));

  amba3_apb_regfile #(.ADDR_SIZE(32), .DATA_SIZE(32), .NUM_REGS(16), .BASE_ADDR(32'h1000),
    .WAIT_STATES(3), .RO_MASK(16'h0008)) dut3 (
    .pclk(pclk), .preset_n(preset_n), .paddr(paddr), .psel(psel3), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pready(pready3), .prdata(prdata3), .pslverr(pslverr3),
    .reg_q(reg_q3), .hw_we(hw_we), .hw_wdata(hw_wdata), .wr_pulse(wr_pulse3), .state_dbg(sd3));

  // Clock / reset
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int cur;  // 0 -> dut0, 1 -> dut3
  logic         pready_s, pslverr_s, sd_s;
  logic [31:0]  prdata_s;
  logic [511:0] reg_q_s;
  logic [15:0]  wr_pulse_s;
  always_comb begin
    pready_s   = cur ? pready3   : pready0;
    pslverr_s  = cur ? pslverr3  : pslverr0;
    sd_s       = cur ? sd3       : sd0;
    prdata_s   = cur ? prdata3   : prdata0;
    reg_q_s    = cur ? reg_q3    : reg_q0;
    wr_pulse_s = cur ? wr_pulse3 : wr_pulse0;
  end

  // Scoreboard
  logic [31:0] exp_q[$];
  logic        experr_q[$];
  logic [31:0] mdl [2][16];
  int checks = 0;
  int errors = 0;

  function automatic logic exp_err(logic [31:0] a, logic wr);
    logic [31:0] off;
    off = a - 32'h1000;
    if (off[1:0] != 2'b00) return 1'b1;
    if ((off >> 2) >= 32'd16) return 1'b1;
    if (wr && (off >> 2) == 32'd3) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [511:0] pack(int d);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = mdl[d][i];
    return r;
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 2; d++) for (int i = 0; i < 16; i++) mdl[d][i] = 32'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  // Driver: full transfer on DUT 'cur'; entered and left at 1 time unit after a posedge.
  task automatic apb_xfer(input logic [31:0] a, input logic wr, input logic [31:0] d);
    logic        e;
    logic [31:0] idx;
    logic [31:0] exp_d;
    logic        exp_e;
    logic [15:0] exp_p;
    int waits;
    logic done;
    e   = exp_err(a, wr);
    idx = (a - 32'h1000) >> 2;
    exp_q.push_back((!wr && !e) ? mdl[cur][idx[3:0]] : 32'h0);
    experr_q.push_back(e);
    paddr = a; pwrite = wr; pwdata = d; penable = 1'b0;
    if (cur != 0) psel3 = 1'b1; else psel0 = 1'b1;
    @(posedge pclk); #1;
    penable = 1'b1;
    waits = 0; done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge pclk);
      if (pready_s) done = 1'b1;
      else begin
        waits++;
        @(posedge pclk); #1;
      end
    end
    exp_d = exp_q.pop_front();
    exp_e = experr_q.pop_front();
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout addr=%h: pready never rose", a);
      psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
      idle(1);
      return;
    end
    if (waits !== (cur ? 3 : 0)) begin
      errors++;
      $display("FAIL wait_states addr=%h: got %0d want %0d", a, waits, cur ? 3 : 0);
    end
    checks++;
    if (prdata_s !== exp_d) begin
      errors++;
      $display("FAIL prdata addr=%h: got %h want %h", a, prdata_s, exp_d);
    end
    checks++;
    if (pslverr_s !== exp_e) begin
      errors++;
      $display("FAIL pslverr addr=%h: got %b want %b", a, pslverr_s, exp_e);
    end
    @(posedge pclk); #1;
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    exp_p = '0;
    if (wr && !e) begin
      mdl[cur][idx[3:0]] = d;
      exp_p[idx[3:0]] = 1'b1;
    end
    checks++;
    if (wr_pulse_s !== exp_p) begin
      errors++;
      $display("FAIL wr_pulse addr=%h: got %h want %h", a, wr_pulse_s, exp_p);
    end
    checks++;
    if (reg_q_s !== pack(cur)) begin
      errors++;
      $display("FAIL reg_q addr=%h: got %h want %h", a, reg_q_s, pack(cur));
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({pready0, pslverr0, prdata0, wr_pulse0, sd0, pready3, pslverr3, prdata3, wr_pulse3, sd3} !== '0
        || reg_q0 !== '0 || reg_q3 !== '0) begin
      errors++;
      $display("FAIL reset_values: pready0=%b prdata0=%h reg_q0=%h want all zero", pready0, prdata0, reg_q0);
    end
    @(posedge pclk); #1;
    preset_n = 1'b1;
    idle(1);
  endtask

  task automatic test_write();
    cur = 0;
    apb_xfer(32'h1008, 1'b1, 32'hDEADBEEF);
    @(posedge pclk); #1;
    checks++;
    if (wr_pulse0 !== 16'h0000) begin
      errors++;
      $display("FAIL wr_pulse_clear: got %h want 0000", wr_pulse0);
    end
  endtask

  task automatic test_read();
    cur = 0;
    apb_xfer(32'h1008, 1'b0, 32'h0);
    idle(1);
  endtask

  task automatic test_wait_states();
    cur = 1;
    apb_xfer(32'h1000, 1'b0, 32'h0);
    apb_xfer(32'h1000, 1'b1, 32'hCAFEF00D);
    apb_xfer(32'h1000, 1'b0, 32'h0);
    idle(1);
  endtask

  task automatic test_errors();
    cur = 0;
    apb_xfer(32'h1006, 1'b1, 32'h11111111);
    apb_xfer(32'h1040, 1'b1, 32'h22222222);
    apb_xfer(32'h0FFC, 1'b0, 32'h0);
    apb_xfer(32'h100C, 1'b1, 32'h33333333);
    cur = 1;
    apb_xfer(32'h100C, 1'b1, 32'h44444444);
    idle(1);
  endtask

  task automatic test_hw_ro();
    for (int i = 0; i < 16; i++) hw_wdata[i*32 +: 32] = $urandom();
    hw_wdata[3*32 +: 32] = 32'h12345678;
    hw_we = 16'h0008;
    @(posedge pclk); #1;
    hw_we = 16'h0000;
    mdl[0][3] = 32'h12345678;
    mdl[1][3] = 32'h12345678;
    checks++;
    if (reg_q0[3*32 +: 32] !== 32'h12345678 || reg_q0 !== pack(0) || reg_q3 !== pack(1)) begin
      errors++;
      $display("FAIL hw_write_ro: got %h want %h", reg_q0[3*32 +: 32], 32'h12345678);
    end
    cur = 0;
    apb_xfer(32'h100C, 1'b0, 32'h0);
    hw_wdata[0 +: 32] = 32'hFFFF0000;
    hw_we = 16'h0001;
    @(posedge pclk); #1;
    hw_we = 16'h0000;
    checks++;
    if (reg_q0 !== pack(0)) begin
      errors++;
      $display("FAIL hw_write_rw_ignored: got %h want %h", reg_q0[31:0], mdl[0][0]);
    end
  endtask

  task automatic test_abort();
    cur = 1;
    paddr = 32'h1014; pwrite = 1'b1; pwdata = 32'h55555555;
    psel3 = 1'b1; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel3 = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    checks++;
    if (sd3 !== 1'b0 || pready3 !== 1'b0 || wr_pulse3 !== 16'h0 || reg_q3 !== pack(1)) begin
      errors++;
      $display("FAIL abort: state=%b pready=%b wr_pulse=%h reg5=%h want 0 0 0000 %h",
               sd3, pready3, wr_pulse3, reg_q3[5*32 +: 32], mdl[1][5]);
    end
    idle(1);
  endtask

  task automatic test_reset_mid();
    cur = 1;
    paddr = 32'h1018; pwrite = 1'b1; pwdata = 32'h66666666;
    psel3 = 1'b1; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    preset_n = 1'b0;
    #1;
    checks++;
    if (pready3 !== 1'b0 || pslverr3 !== 1'b0 || prdata3 !== 32'h0 || wr_pulse3 !== 16'h0
        || sd3 !== 1'b0 || reg_q3 !== '0 || reg_q0 !== '0) begin
      errors++;
      $display("FAIL reset_mid: state=%b reg_q3=%h reg_q0=%h want all zero", sd3, reg_q3, reg_q0);
    end
    psel3 = 1'b0; penable = 1'b0;
    clear_model();
    @(posedge pclk); #1;
    preset_n = 1'b1;
    idle(1);
    apb_xfer(32'h1018, 1'b1, 32'h77777777);
    apb_xfer(32'h1018, 1'b0, 32'h0);
    idle(1);
  endtask

  task automatic test_back_to_back();
    cur = 0;
    apb_xfer(32'h1004, 1'b1, 32'hA5A5A5A5);
    apb_xfer(32'h1004, 1'b0, 32'h0);
    apb_xfer(32'h1020, 1'b1, 32'h0BADF00D);
    apb_xfer(32'h1020, 1'b0, 32'h0);
    idle(1);
  endtask

  task automatic test_random();
    logic [31:0] a;
    int r;
    for (int n = 0; n < 24; n++) begin
      cur = $urandom_range(0, 1);
      r = $urandom_range(0, 19);
      if (r < 16)       a = 32'h1000 + 32'(4 * r);
      else if (r == 16) a = 32'h1002;
      else if (r == 17) a = 32'h1040 + 32'(4 * $urandom_range(0, 3));
      else if (r == 18) a = 32'h0FF0;
      else              a = 32'h1001 + 32'(4 * $urandom_range(0, 15));
      apb_xfer(a, 1'($urandom_range(0, 1)), $urandom());
      if ($urandom_range(0, 1) == 1) idle(1);
    end
  endtask

  initial begin
    preset_n = 1'b0; paddr = '0; pwdata = '0; psel0 = 1'b0; psel3 = 1'b0;
    penable = 1'b0; pwrite = 1'b0; hw_we = '0; hw_wdata = '0; cur = 0;
    clear_model();
    test_reset();
    test_write();
    test_read();
    test_wait_states();
    test_errors();
    test_hw_ro();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
